// File: rtl/chi_ring_link_ctrl.sv
// CHI link-layer controller for ring-node local ports: TX/RX LINKACTIVE handshakes
// and per-channel L-credit accounting in both directions.
module chi_ring_link_ctrl #(
    parameter int NUM_PORTS = 2,
    parameter int NUM_CH    = 4,
    parameter int MAX_CRD   = 15,
    parameter int RX_CRD    = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS-1:0]        link_en,
    output logic [NUM_PORTS-1:0]        TXLINKACTIVEREQ,
    input  logic [NUM_PORTS-1:0]        TXLINKACTIVEACK,
    input  logic [NUM_PORTS-1:0]        RXLINKACTIVEREQ,
    output logic [NUM_PORTS-1:0]        RXLINKACTIVEACK,
    output logic [NUM_PORTS-1:0]        TXSACTIVE,
    input  logic [NUM_PORTS*NUM_CH-1:0] TXLCRDV,
    input  logic [NUM_PORTS*NUM_CH-1:0] tx_flit_send,
    output logic [NUM_PORTS*NUM_CH-1:0] tx_crd_avail,
    output logic [NUM_PORTS*NUM_CH-1:0] tx_lcrd_rtn,
    input  logic [NUM_PORTS*NUM_CH-1:0] RXFLITV,
    input  logic [NUM_PORTS*NUM_CH-1:0] rx_buf_free,
    output logic [NUM_PORTS*NUM_CH-1:0] RXLCRDV,
    output logic [NUM_PORTS-1:0]        link_up,
    output logic [NUM_PORTS-1:0]        crd_err
);
    localparam int CW = $clog2(MAX_CRD + 1);
    localparam int NK = NUM_PORTS * NUM_CH;
    localparam logic [CW-1:0] CRD_MAX = CW'(MAX_CRD);
    localparam logic [CW-1:0] CRD_RX  = CW'(RX_CRD);
    localparam logic [CW-1:0] ONE     = CW'(1);

    // Encoded {REQ,ACK} so TXLINKACTIVEREQ is taken straight from the state register.
    typedef enum logic [1:0] {
        TX_STOP       = 2'b00,
        TX_ACTIVATE   = 2'b10,
        TX_RUN        = 2'b11,
        TX_DEACTIVATE = 2'b01
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_STOP,
        RX_RUN,
        RX_DEACT
    } rx_state_t;

    tx_state_t            tx_st   [NUM_PORTS];
    rx_state_t            rx_st   [NUM_PORTS];
    logic [CW-1:0]        tx_cnt  [NK];
    logic [CW-1:0]        tx_cnt_nx [NK];
    logic [CW-1:0]        rx_pool [NK];
    logic [CW-1:0]        rx_pool_nx [NK];
    logic [CW-1:0]        rx_out  [NK];
    logic [CW-1:0]        rx_out_nx [NK];
    logic [NK-1:0]        rx_issue;
    logic [NUM_PORTS-1:0] rx_idle;
    logic [NUM_PORTS-1:0] tx_err;
    logic [NUM_PORTS-1:0] rx_err;

    always_comb begin
        tx_cnt_nx    = tx_cnt;
        tx_crd_avail = '0;
        tx_lcrd_rtn  = '0;
        tx_err       = '0;
        for (int unsigned k = 0; k < NK; k++) begin
            case (tx_st[k / NUM_CH])
                TX_RUN: begin
                    tx_crd_avail[k] = (tx_cnt[k] != '0);
                    if (TXLCRDV[k] && tx_flit_send[k]) begin
                        if (tx_cnt[k] == '0) tx_err[k / NUM_CH] = 1'b1;
                    end else if (TXLCRDV[k]) begin
                        if (tx_cnt[k] == CRD_MAX) tx_err[k / NUM_CH] = 1'b1;
                        else                      tx_cnt_nx[k] = tx_cnt[k] + ONE;
                    end else if (tx_flit_send[k]) begin
                        if (tx_cnt[k] == '0) tx_err[k / NUM_CH] = 1'b1;
                        else                 tx_cnt_nx[k] = tx_cnt[k] - ONE;
                    end
                end
                TX_ACTIVATE, TX_DEACTIVATE: begin
                    // Each asserted return consumes one credit, so returns run back-to-back.
                    tx_lcrd_rtn[k] = (tx_st[k / NUM_CH] == TX_DEACTIVATE) && (tx_cnt[k] != '0);
                    if (tx_flit_send[k]) tx_err[k / NUM_CH] = 1'b1;
                    if (TXLCRDV[k] && !tx_lcrd_rtn[k]) begin
                        if (tx_cnt[k] == CRD_MAX) tx_err[k / NUM_CH] = 1'b1;
                        else                      tx_cnt_nx[k] = tx_cnt[k] + ONE;
                    end else if (tx_lcrd_rtn[k] && !TXLCRDV[k]) begin
                        tx_cnt_nx[k] = tx_cnt[k] - ONE;
                    end
                end
                default: begin
                    if (tx_flit_send[k]) tx_err[k / NUM_CH] = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        rx_issue   = '0;
        rx_idle    = '1;
        rx_err     = '0;
        rx_pool_nx = rx_pool;
        rx_out_nx  = rx_out;
        for (int unsigned k = 0; k < NK; k++) begin
            rx_issue[k] = (rx_st[k / NUM_CH] == RX_RUN) && (rx_pool[k] != '0) && (rx_out[k] != CRD_MAX);
            if (rx_out[k] != '0) rx_idle[k / NUM_CH] = 1'b0;
            if (rx_issue[k]) begin
                rx_pool_nx[k] = rx_pool[k] - ONE;
                rx_out_nx[k]  = rx_out[k] + ONE;
            end
            if (rx_buf_free[k] && (rx_pool_nx[k] < CRD_RX)) rx_pool_nx[k] = rx_pool_nx[k] + ONE;
            if (RXFLITV[k]) begin
                if (rx_out[k] == '0) rx_err[k / NUM_CH] = 1'b1;
                else                 rx_out_nx[k] = rx_out_nx[k] - ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_st   <= '{default: TX_STOP};
            rx_st   <= '{default: RX_STOP};
            tx_cnt  <= '{default: '0};
            rx_pool <= '{default: CRD_RX};
            rx_out  <= '{default: '0};
            RXLCRDV <= '0;
            crd_err <= '0;
        end else begin
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                case (tx_st[p])
                    TX_STOP:       if (link_en[p])          tx_st[p] <= TX_ACTIVATE;
                    TX_ACTIVATE:   if (TXLINKACTIVEACK[p])  tx_st[p] <= TX_RUN;
                    TX_RUN:        if (!link_en[p])         tx_st[p] <= TX_DEACTIVATE;
                    TX_DEACTIVATE: if (!TXLINKACTIVEACK[p]) tx_st[p] <= TX_STOP;
                    default:                                tx_st[p] <= TX_STOP;
                endcase
                case (rx_st[p])
                    RX_STOP:  if (RXLINKACTIVEREQ[p])  rx_st[p] <= RX_RUN;
                    RX_RUN:   if (!RXLINKACTIVEREQ[p]) rx_st[p] <= RX_DEACT;
                    RX_DEACT: if (rx_idle[p])          rx_st[p] <= RX_STOP;
                    default:                           rx_st[p] <= RX_STOP;
                endcase
            end
            tx_cnt  <= tx_cnt_nx;
            rx_pool <= rx_pool_nx;
            rx_out  <= rx_out_nx;
            RXLCRDV <= rx_issue;
            crd_err <= crd_err | tx_err | rx_err;
        end
    end

    always_comb begin
        TXLINKACTIVEREQ = '0;
        TXSACTIVE       = '0;
        RXLINKACTIVEACK = '0;
        link_up         = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            TXLINKACTIVEREQ[p] = tx_st[p][1];
            TXSACTIVE[p]       = (tx_st[p] != TX_STOP);
            RXLINKACTIVEACK[p] = (rx_st[p] != RX_STOP);
            link_up[p]         = (tx_st[p] == TX_RUN) && (rx_st[p] == RX_RUN);
        end
    end
endmodule

// File: tb/tb_chi_ring_link_ctrl.sv
// Scoreboard bench for chi_ring_link_ctrl: stimulus queues timed expectations and
// RXLCRDV grants, a negedge monitor pops and compares them.
module tb_chi_ring_link_ctrl;
    localparam int NP = 2;
    localparam int NC = 4;
    localparam int NK = NP * NC;
    localparam int unsigned S_TXREQ = 0, S_RXACK = 1, S_TXSACT = 2, S_LINKUP = 3,
                            S_ERR = 4, S_AVAIL = 5, S_RTN = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NP-1:0] link_en = '0, TXLINKACTIVEACK = '0, RXLINKACTIVEREQ = '0;
    logic [NK-1:0] TXLCRDV = '0, tx_flit_send = '0, RXFLITV = '0, rx_buf_free = '0;
    logic [NP-1:0] TXLINKACTIVEREQ, RXLINKACTIVEACK, TXSACTIVE, link_up, crd_err;
    logic [NK-1:0] tx_crd_avail, tx_lcrd_rtn, RXLCRDV;

    int unsigned cyc = 0;
    int unsigned n_chk = 0;
    int unsigned n_fail = 0;

    typedef struct {
        int unsigned cyc;
        int unsigned sel;
        logic [31:0] val;
        string       nm;
    } exp_t;
    exp_t          exp_q[$];
    logic [NK-1:0] crd_q[$];

    chi_ring_link_ctrl #(.NUM_PORTS(NP), .NUM_CH(NC), .MAX_CRD(15), .RX_CRD(4)) dut (
        .clk(clk), .rst(rst), .link_en(link_en),
        .TXLINKACTIVEREQ(TXLINKACTIVEREQ), .TXLINKACTIVEACK(TXLINKACTIVEACK),
        .RXLINKACTIVEREQ(RXLINKACTIVEREQ), .RXLINKACTIVEACK(RXLINKACTIVEACK),
        .TXSACTIVE(TXSACTIVE), .TXLCRDV(TXLCRDV), .tx_flit_send(tx_flit_send),
        .tx_crd_avail(tx_crd_avail), .tx_lcrd_rtn(tx_lcrd_rtn), .RXFLITV(RXFLITV),
        .rx_buf_free(rx_buf_free), .RXLCRDV(RXLCRDV), .link_up(link_up), .crd_err(crd_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] sig(input int unsigned s);
        case (s)
            S_TXREQ:  return 32'(TXLINKACTIVEREQ);
            S_RXACK:  return 32'(RXLINKACTIVEACK);
            S_TXSACT: return 32'(TXSACTIVE);
            S_LINKUP: return 32'(link_up);
            S_ERR:    return 32'(crd_err);
            S_AVAIL:  return 32'(tx_crd_avail);
            default:  return 32'(tx_lcrd_rtn);
        endcase
    endfunction

    task automatic step(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // d = 0 checks the current cycle, d = 1 the cycle after the next edge, etc.
    task automatic chk(input int unsigned d, input int unsigned sel, input logic [31:0] v, input string nm);
        exp_t e;
        e.cyc = cyc + d;
        e.sel = sel;
        e.val = v;
        e.nm  = nm;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        for (int i = int'(exp_q.size()) - 1; i >= 0; i--) begin
            if (exp_q[i].cyc <= cyc) begin
                n_chk++;
                if (exp_q[i].cyc != cyc || sig(exp_q[i].sel) !== exp_q[i].val) begin
                    n_fail++;
                    $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                             exp_q[i].nm, sig(exp_q[i].sel), exp_q[i].val, cyc);
                end
                exp_q.delete(i);
            end
        end
        if (RXLCRDV != '0) begin
            n_chk++;
            if (crd_q.size() == 0) begin
                n_fail++;
                $display("FAIL rxlcrdv_extra: got 0x%0h, expected no grant (cycle %0d)", RXLCRDV, cyc);
            end else begin
                logic [NK-1:0] want;
                want = crd_q.pop_front();
                if (RXLCRDV !== want) begin
                    n_fail++;
                    $display("FAIL rxlcrdv: got 0x%0h, expected 0x%0h (cycle %0d)", RXLCRDV, want, cyc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at 100000 ns, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        step(2);
        chk(0, S_TXREQ, 0, "rst_txreq");   chk(0, S_RXACK, 0, "rst_rxack");
        chk(0, S_TXSACT, 0, "rst_txsact"); chk(0, S_LINKUP, 0, "rst_linkup");
        chk(0, S_ERR, 0, "rst_err");       chk(0, S_AVAIL, 0, "rst_avail");
        chk(0, S_RTN, 0, "rst_rtn");
        rst = 1'b0;
        step(1);

        // T1 + T4: bring port 0 up; RX grants 4 credits on every channel of port 0
        link_en = 2'b01;
        RXLINKACTIVEREQ = 2'b01;
        for (int i = 0; i < 4; i++) crd_q.push_back(8'h0F);
        chk(1, S_TXREQ, 2'b01, "t1_req");   chk(1, S_TXSACT, 2'b01, "t1_txsact");
        chk(1, S_RXACK, 2'b01, "t4_rxack"); chk(1, S_LINKUP, 2'b00, "t1_linkup_act");
        step(2);
        TXLINKACTIVEACK = 2'b01;
        chk(0, S_LINKUP, 2'b00, "t1_linkup_pre");
        chk(1, S_LINKUP, 2'b01, "t1_linkup");
        step(1);

        // T2: 3 grants, then grant + send together
        chk(0, S_AVAIL, 8'h00, "t2_avail0");
        TXLCRDV = 8'h01;
        chk(1, S_AVAIL, 8'h01, "t2_avail1");
        step(3);
        tx_flit_send = 8'h01;
        step(1);
        TXLCRDV = '0;
        tx_flit_send = '0;
        chk(0, S_AVAIL, 8'h01, "t2_avail3");
        chk(0, S_ERR, 2'b00, "t2_err");
        // single grant then single send on channel 2
        TXLCRDV = 8'h04;
        step(1);
        TXLCRDV = '0;
        chk(0, S_AVAIL, 8'h05, "t2_ch2_up");
        tx_flit_send = 8'h04;
        step(1);
        tx_flit_send = '0;
        chk(0, S_AVAIL, 8'h01, "t2_ch2_down");

        // T3: deactivate with 3 credits held
        link_en = 2'b00;
        chk(1, S_TXREQ, 2'b00, "t3_req");    chk(1, S_LINKUP, 2'b00, "t3_linkup");
        chk(1, S_AVAIL, 8'h00, "t3_avail");  chk(1, S_TXSACT, 2'b01, "t3_txsact");
        chk(1, S_RTN, 8'h01, "t3_rtn1");     chk(2, S_RTN, 8'h01, "t3_rtn2");
        chk(3, S_RTN, 8'h01, "t3_rtn3");     chk(4, S_RTN, 8'h00, "t3_rtn_done");
        step(4);
        TXLINKACTIVEACK = 2'b00;
        chk(0, S_TXSACT, 2'b01, "t3_txsact_deact");
        chk(1, S_TXSACT, 2'b00, "t3_stop");
        step(1);

        // T5: consume 2 of 4 outstanding, drop RX REQ, re-assert it while draining
        RXFLITV = 8'h0F;
        step(2);
        RXFLITV = '0;
        RXLINKACTIVEREQ = 2'b00;
        chk(1, S_RXACK, 2'b01, "t5_ack_deact");
        step(2);
        chk(0, S_RXACK, 2'b01, "t5_ack_hold");
        RXLINKACTIVEREQ = 2'b01;
        RXFLITV = 8'h0F;
        step(2);
        RXFLITV = '0;
        chk(0, S_RXACK, 2'b01, "t5_ack_last");
        chk(1, S_RXACK, 2'b00, "t5_ack_drop");
        chk(2, S_RXACK, 2'b01, "t5_reactivate");
        step(2);
        // pool is empty after T4; one freed entry yields exactly one grant
        crd_q.push_back(8'h01);
        rx_buf_free = 8'h01;
        step(1);
        rx_buf_free = '0;
        step(3);

        // T6a: send with zero credits on port 0 channel 1
        link_en = 2'b01;
        step(1);
        TXLINKACTIVEACK = 2'b01;
        step(1);
        chk(0, S_AVAIL, 8'h00, "t6_avail0");
        chk(0, S_ERR, 2'b00, "t6_err_pre");
        tx_flit_send = 8'h02;
        chk(1, S_ERR, 2'b01, "t6_err_send");
        step(1);
        tx_flit_send = '0;
        chk(0, S_AVAIL, 8'h00, "t6_held0");
        TXLCRDV = 8'h02;
        chk(1, S_AVAIL, 8'h02, "t6_after_grant");
        step(1);
        TXLCRDV = '0;

        // T6b: port 1, 16 grants on channel 0 saturate at 15
        link_en = 2'b11;
        step(1);
        TXLINKACTIVEACK = 2'b11;
        step(1);
        TXLCRDV = 8'h10;
        step(15);
        chk(0, S_ERR, 2'b01, "t6_err_15");
        chk(0, S_AVAIL, 8'h12, "t6_avail_15");
        step(1);
        TXLCRDV = '0;
        chk(0, S_ERR, 2'b11, "t6_err_16");
        link_en = 2'b01;
        for (int unsigned i = 1; i <= 15; i++) chk(i, S_RTN, 8'h10, "t6_rtn15");
        chk(16, S_RTN, 8'h00, "t6_rtn_done");
        step(17);
        TXLINKACTIVEACK = 2'b01;
        step(2);
        chk(0, S_ERR, 2'b11, "t6_err_sticky");
        chk(0, S_TXSACT, 2'b01, "t6_p1_stop");
        step(1);

        // Asynchronous reset mid-operation
        rst = 1'b1;
        chk(0, S_TXREQ, 0, "arst_txreq");   chk(0, S_RXACK, 0, "arst_rxack");
        chk(0, S_TXSACT, 0, "arst_txsact"); chk(0, S_ERR, 0, "arst_err");
        chk(0, S_AVAIL, 0, "arst_avail");
        step(2);

        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_checks: got %0d unchecked, expected 0", exp_q.size());
        end
        n_chk++;
        if (crd_q.size() != 0) begin
            n_fail++;
            $display("FAIL rxlcrdv_missing: got %0d grants outstanding, expected 0", crd_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
